// File: rtl/bidirectional_piso_pkg.sv
// bidirectional_piso shared types: FSM state encoding and shift-direction
// constants, shared with bidirectional_reg users.
package bidirectional_piso_pkg;

  typedef logic [0:0] state_t;

  localparam state_t IDLE  = 1'b0;
  localparam state_t SHIFT = 1'b1;

  typedef logic dir_t;

  // 0 pairs with the receiver's left shift, 1 with its right shift.
  localparam dir_t DIR_MSB_FIRST = 1'b0;
  localparam dir_t DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/bidirectional_piso_if.sv
// bidirectional_piso bus: load handshake (valid/ready/data/dir), shift
// enable, and the serial stream outputs (q/q_valid/last/busy).
interface bidirectional_piso_if
  import bidirectional_piso_pkg::*;
#(
  parameter int MSB = 4
) ();

  logic           en;
  logic           load_valid;
  logic           load_ready;
  logic [MSB-1:0] load_data;
  dir_t           load_dir;
  logic           q;
  logic           q_valid;
  logic           last;
  logic           busy;

  modport master (
    output en,
    output load_valid,
    input  load_ready,
    output load_data,
    output load_dir,
    input  q,
    input  q_valid,
    input  last,
    input  busy
  );

  modport slave (
    input  en,
    input  load_valid,
    output load_ready,
    input  load_data,
    input  load_dir,
    output q,
    output q_valid,
    output last,
    output busy
  );

endinterface

// File: rtl/bidirectional_piso.sv
// Parallel-in serial-out shifter, MSB- or LSB-first per loaded word.
// Ports: clk, rst (sync, active-high), bus (slave: load handshake, en, q/q_valid/last/busy).
module bidirectional_piso
  import bidirectional_piso_pkg::*;
#(
  parameter int MSB = 4
) (
  input logic               clk,
  input logic               rst,
  bidirectional_piso_if.slave bus
);

  localparam int CW = $clog2(MSB + 1);

  state_t         state;
  logic [MSB-1:0] shreg;
  dir_t           dir_q;
  logic [CW-1:0]  cnt;
  logic           q_r;
  logic           q_valid_r;
  logic           last_r;
  logic           fin;

  // Final bit of the word goes out on this enabled cycle.
  assign fin = (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      dir_q     <= DIR_MSB_FIRST;
      cnt       <= '0;
      q_r       <= 1'b0;
      q_valid_r <= 1'b0;
      last_r    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          q_valid_r <= 1'b0;
          last_r    <= 1'b0;
          if (bus.load_valid) begin
            shreg <= bus.load_data;
            dir_q <= bus.load_dir;
            cnt   <= CW'(MSB);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (bus.en) begin
            q_valid_r <= 1'b1;
            cnt       <= cnt - CW'(1);
            last_r    <= fin;
            if (dir_q == DIR_LSB_FIRST) begin
              q_r   <= shreg[0];
              shreg <= {1'b0, shreg[MSB-1:1]};
            end else begin
              q_r   <= shreg[MSB-1];
              shreg <= {shreg[MSB-2:0], 1'b0};
            end
            if (fin) begin
              state <= IDLE;
            end
          end else begin
            q_valid_r <= 1'b0;
            last_r    <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.load_ready = (state == IDLE);
  assign bus.busy       = (state == SHIFT);
  assign bus.q          = q_r;
  assign bus.q_valid    = q_valid_r;
  assign bus.last       = last_r;

  // last is only ever a qualifier on a valid bit.
  a_last_valid : assert property (
    @(posedge clk) disable iff (rst)
    last_r |-> q_valid_r
  );

  // Counter must never be zero while a word is in flight.
  a_cnt_nz : assert property (
    @(posedge clk) disable iff (rst)
    (state == SHIFT) |-> (cnt != '0)
  );

endmodule

// File: doc/bidirectional_piso.md
# bidirectional_piso

Parallel-in, serial-out shift register with selectable shift direction. It is the transmit-side counterpart of `bidirectional_reg`. It accepts an `MSB`-bit word through a ready/valid load handshake and emits the word one bit per enabled clock on `q`/`q_valid`, MSB-first or LSB-first. When `q`/`q_valid` drive `bidirectional_reg`'s `d`/`en` and both blocks use the same `dir`, the receiver holds the original word after the final bit.

## Interface
- `MSB`, default 4: word width in bits; legal range ≥ 2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  shift enable; while a word is in flight, each cycle with `en`=1 emits one bit.
- `load_valid`  in  1  `load_data`/`load_dir` are valid.
- `load_ready`  out  1  block can accept a word; high exactly when the FSM is in IDLE (combinational from state).
- `load_data`  in  `MSB`  word to serialize.
- `load_dir`  in  1  0 = MSB-first, matching the receiver's left shift; 1 = LSB-first, matching the receiver's right shift.
- `q`  out  1  serial data bit, registered.
- `q_valid`  out  1  `q` carries a new bit this cycle, registered.
- `last`  out  1  high together with `q_valid` on the final bit of a word, registered.
- `busy`  out  1  high when the FSM is in SHIFT; the complement of `load_ready`.

## Operation
- FSM states: IDLE, SHIFT.
- IDLE:
  - `load_ready`=1.
  - On `load_valid`=1: capture `load_data` into `shreg` and `load_dir` into `dir_q`, set `cnt`=`MSB`, go to SHIFT.
  - `en` is ignored in IDLE.
- SHIFT with `en`=1:
  - `q` <= `dir_q` ? `shreg[0]` : `shreg[MSB-1]`.
  - `q_valid` <= 1.
  - `shreg` shifts: left with 0 fill when `dir_q`=0; right with 0 fill when `dir_q`=1.
  - `cnt` <= `cnt`-1.
  - If `cnt`==1: `last` <= 1 and the next state is IDLE. Otherwise `last` <= 0.
- SHIFT with `en`=0:
  - `q_valid` <= 0 and `last` <= 0.
  - `q`, `shreg`, `cnt` and the state all hold.
- In IDLE, `q_valid` <= 0, `last` <= 0, and `q` holds its last driven value.
- `load_valid` while busy is ignored (`load_ready`=0). The word is not queued.
- `load_dir` is sampled only at accept; changes during SHIFT have no effect.
- `cnt` width is $clog2(`MSB`+1). `cnt` never underflows: leaving SHIFT at `cnt`==1 is mandatory.
- Reset (any state, including mid-word):
  - state IDLE, `shreg`=0, `dir_q`=0, `cnt`=0.
  - `q`=0, `q_valid`=0, `last`=0.
  - Hence `load_ready`=1 and `busy`=0.
  - The in-flight word is abandoned with no `last`.
- `rst` has priority over the load handshake and over `en`.

## Timing
- Accept at edge A. The earliest first bit appears on `q`/`q_valid` after edge A+1, provided `en`=1 in the cycle before A+1.
- With `en` held high, bit k (k=0..`MSB`-1) is driven after edge A+1+k. `last` is set after edge A+`MSB`.
- The FSM is in IDLE from edge A+`MSB`, so `load_ready` is high in the cycle in which `last` is visible.
- The next accept can occur at edge A+`MSB`+1.
- With `en` held high, the word period is therefore `MSB`+1 cycles; the dead cycle is required.
- Every `en`=0 cycle in SHIFT stretches the word by one cycle. No bit is skipped or repeated.

## Structure
- Shared package holds:
  - FSM state typedef (IDLE, SHIFT).
  - Direction constants: `DIR_MSB_FIRST`=0, `DIR_LSB_FIRST`=1.
  - These are shared with `bidirectional_reg` users.
- Single flat module. The shift register, down-counter and two-state FSM are small enough that no sub-module is warranted.

## Test plan
- `MSB`=4, `load_data`=4'b1011, `load_dir`=0, `en`=1 continuous -> `q`=1,0,1,1 on four consecutive `q_valid` cycles; `last` only on the 4th; `load_ready` low for exactly 4 cycles after accept.
- Same word, `load_dir`=1 -> `q`=1,1,0,1; `last` on the 4th.
- `en` pattern 1,0,0,1,1,0,1 during 4'b0110 MSB-first -> exactly four `q_valid` pulses carrying 0,1,1,0; `q` and `cnt` hold across gaps.
- `load_valid` with 4'b1111 asserted while shifting 4'b0001 -> ignored; output stream is 0,0,0,1; the next accept occurs only after `load_ready` returns high.
- `rst` asserted after the 2nd bit of 4'b1010 -> next cycle: `q`=0, `q_valid`=0, `last`=0, `busy`=0, `load_ready`=1. A new load of 4'b0101 then serializes cleanly.
- Loopback into `bidirectional_reg` (`d`=`q`, `en`=`q_valid`, same `dir`, its `rstn`=~`rst`), random `MSB`=8 words with random `en` gaps, both directions -> the receiver's `out` equals the loaded word in the cycle after each `last`.
